// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master.
// Contents:
//   state_t           - transfer sequencer states
//   SPI_MODE0..3      - SPI modes encoded as {cpol, cpha}
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LEAD  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: down-counter reloaded on transfer accept and at
// every phase boundary, so each phase lasts exactly reload+1 cycles.
// Ports:
//   clk, rst  - clock, async active-high reset
//   load      - transfer accepted this cycle
//   run       - a transfer is in progress
//   reload    - half-period length minus one
//   tick_c    - combinational one-cycle pulse on the last cycle of a phase
module spi_clk_tick #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] reload,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt;

    assign tick_c = run && (cnt == '0);

    // Reload instead of wrapping so the maximum divider never overflows mid-phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || tick_c) begin
            cnt <= reload;
        end else if (run) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, runtime CPOL/CPHA,
// programmable SCLK divider, bit order and multiple active-low chip selects.
// Optional feature macro: SPI_MASTER_LOOPBACK_EN (adds loopback_i; receive
// path takes the internal mosi and the external pins stay idle).
// Ports:
//   clk_i, rst_i                 - clock, async active-high reset
//   start_i                      - transfer request, accepted only when idle
//   data_in_bi, cpol_i, cpha_i,
//   div_i, cs_sel_i              - transfer configuration, latched on accept
//   busy_o, done_o, data_out_bo  - status and received word
//   spi_miso_i, spi_mosi_o,
//   spi_sclk_o, spi_cs_n_o       - SPI pins
module spi_master_param
    import spi_pkg::*;
#(
    parameter int unsigned  DATA_W    = 8,
    parameter int unsigned  DIV_W     = 8,
    parameter int unsigned  NUM_CS    = 1,
    parameter bit           LSB_FIRST = 1'b1,
    localparam int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_in_bi,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [CS_W-1:0]   cs_sel_i,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_out_bo,
    input  logic              spi_miso_i,
    output logic              spi_mosi_o,
    output logic              spi_sclk_o,
    output logic [NUM_CS-1:0] spi_cs_n_o
);

    localparam int unsigned   BW       = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state, state_d;
    logic [DATA_W-1:0] tx_q, rx_q, rx_d;
    logic [BW-1:0]     bit_q, bit_d, next_bit, sample_pos;
    logic [DIV_W-1:0]  div_q;
    logic [CS_W-1:0]   cs_q, cs_idx_d;
    logic              cpol_q, cpol_d, cpha_q;
    logic              mosi_q, mosi_d, sclk_q, sclk_d, cs_low_q, cs_low_d;
    logic              done_d, sample_en, sample_bit, accept, tick, lb_d;

    // Wire position of logical bit b, shared by transmit and receive.
    function automatic logic [BW-1:0] bit_pos(input logic [BW-1:0] b);
        return LSB_FIRST ? b : LAST_BIT - b;
    endfunction

    assign accept     = (state == ST_IDLE) && start_i;
    assign next_bit   = bit_q + BW'(1);
    assign cpol_d     = accept ? cpol_i : cpol_q;
    assign cs_idx_d   = !accept ? cs_q : ((32'(cs_sel_i) >= NUM_CS) ? '0 : cs_sel_i);
    assign sample_bit = lb_d ? mosi_q : spi_miso_i;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lb_q <= 1'b0;
        end else if (accept) begin
            lb_q <= loopback_i;
        end
    end

    assign lb_d = accept ? loopback_i : lb_q;
`else
    assign lb_d = 1'b0;
`endif

    spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (accept),
        .run    (state != ST_IDLE),
        .reload (accept ? div_i : div_q),
        .tick_c (tick)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Sequencer: leading edge on LEAD entry, trailing edge on TRAIL entry.
    always_comb begin
        state_d    = state;
        bit_d      = bit_q;
        mosi_d     = mosi_q;
        sclk_d     = sclk_q;
        cs_low_d   = cs_low_q;
        done_d     = 1'b0;
        sample_en  = 1'b0;
        sample_pos = bit_q;
        case (state)
            ST_IDLE: begin
                sclk_d   = cpol_q;
                mosi_d   = 1'b0;
                cs_low_d = 1'b0;
                if (start_i) begin
                    state_d  = ST_SETUP;
                    bit_d    = '0;
                    sclk_d   = cpol_i;
                    cs_low_d = 1'b1;
                    mosi_d   = cpha_i ? 1'b0 : data_in_bi[bit_pos('0)];
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_LEAD;
                    sclk_d  = ~cpol_q;
                    if (cpha_q) mosi_d = tx_q[bit_pos(bit_q)];
                    else        sample_en = 1'b1;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_TRAIL;
                    sclk_d  = cpol_q;
                    if (cpha_q)                  sample_en = 1'b1;
                    else if (bit_q != LAST_BIT)  mosi_d = tx_q[bit_pos(next_bit)];
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d    = ST_LEAD;
                        bit_d      = next_bit;
                        sclk_d     = ~cpol_q;
                        sample_pos = next_bit;
                        if (cpha_q) mosi_d = tx_q[bit_pos(next_bit)];
                        else        sample_en = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d  = ST_IDLE;
                    cs_low_d = 1'b0;
                    mosi_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receive assembly.
    always_comb begin
        rx_d = rx_q;
        if (sample_en) rx_d[bit_pos(sample_pos)] = sample_bit;
    end

    // Datapath and registered pins; loopback holds the pins at their idle levels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q        <= '0;
            rx_q        <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            cs_q        <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            mosi_q      <= 1'b0;
            sclk_q      <= 1'b0;
            cs_low_q    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            data_out_bo <= '0;
            spi_mosi_o  <= 1'b0;
            spi_sclk_o  <= 1'b0;
            spi_cs_n_o  <= '1;
        end else begin
            if (accept) begin
                tx_q   <= data_in_bi;
                cpha_q <= cpha_i;
                div_q  <= div_i;
            end
            rx_q     <= rx_d;
            bit_q    <= bit_d;
            cs_q     <= cs_idx_d;
            cpol_q   <= cpol_d;
            mosi_q   <= mosi_d;
            sclk_q   <= sclk_d;
            cs_low_q <= cs_low_d;
            busy_o   <= (state_d != ST_IDLE);
            done_o   <= done_d;
            if (done_d) data_out_bo <= rx_q;
            spi_mosi_o <= mosi_d && !lb_d;
            spi_sclk_o <= lb_d ? cpol_d : sclk_d;
            spi_cs_n_o <= (cs_low_d && !lb_d) ? ~(NUM_CS'(1) << cs_idx_d) : '1;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: a behavioural SPI slave on the pins,
// expectations queued at issue time and checked on every done_o pulse.
module tb_spi_master_param;
    import spi_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned DIVW = 8;
    localparam int unsigned NCS  = 5;
    localparam int unsigned CSW  = 3;
    localparam bit          LSBF = 1'b1;

    typedef struct {
        logic [DW-1:0]  tx;
        logic [DW-1:0]  rx;
        logic [NCS-1:0] cs;
        int             busy;
        int             edges;
        int             falls;
        logic           cpol;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic            clk = 1'b0, rst = 1'b0, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic [DIVW-1:0] div = '0;
    logic [CSW-1:0]  cs_sel = '0;
    logic            busy, done, mosi, sclk;
    logic            miso = 1'b0;
    logic [DW-1:0]   data_out;
    logic [NCS-1:0]  cs_n;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic            loopback = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(DW), .DIV_W(DIVW), .NUM_CS(NCS), .LSB_FIRST(LSBF)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .data_in_bi  (data_in),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .div_i       (div),
        .cs_sel_i    (cs_sel),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback_i  (loopback),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .data_out_bo (data_out),
        .spi_miso_i  (miso),
        .spi_mosi_o  (mosi),
        .spi_sclk_o  (sclk),
        .spi_cs_n_o  (cs_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [DW-1:0] w, input int k);
        return LSBF ? w[k] : w[DW-1-k];
    endfunction

    // Behavioural slave: shifts its word out and captures mosi per CPOL/CPHA.
    logic [DW-1:0]  slv_word = '0, slv_cap = '0;
    logic           slv_cpol = 1'b0, slv_cpha = 1'b0;
    int             slv_k = 0, sclk_edges = 0, cs_falls = 0;
    logic [NCS-1:0] cs_pat = '1;
    logic           sclk_prev = 1'b0, cs_act_prev = 1'b0;

    always @(sclk or cs_n) begin : slave
        logic cs_act, leading;
        cs_act = (cs_n != {NCS{1'b1}});
        if (cs_act && !cs_act_prev) begin
            cs_falls++;
            cs_pat  = cs_n;
            slv_k   = 0;
            slv_cap = '0;
            if (!slv_cpha) miso = bit_of(slv_word, 0);
        end else if (cs_act && sclk != sclk_prev) begin
            sclk_edges++;
            leading = (sclk != slv_cpol);
            if (leading != slv_cpha) begin
                if (slv_k < DW) slv_cap[LSBF ? slv_k : DW-1-slv_k] = mosi;
                if (slv_cpha) slv_k++;
            end else begin
                if (!slv_cpha) slv_k++;
                if (slv_k < DW) miso = bit_of(slv_word, slv_k);
            end
        end
        sclk_prev   = sclk;
        cs_act_prev = cs_act;
    end

    // Monitor: pops one expectation per completion.
    int busy_cnt = 0, edge_base = 0, fall_base = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            sb.delete();
            busy_cnt  = 0;
            edge_base = sclk_edges;
            fall_base = cs_falls;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("data_out", 32'(data_out), 32'(e.rx));
                    check("busy_len", 32'(busy_cnt), 32'(e.busy));
                    check("sclk_edges", 32'(sclk_edges - edge_base), 32'(e.edges));
                    check("cs_falls", 32'(cs_falls - fall_base), 32'(e.falls));
                    if (e.falls == 1) begin
                        check("cs_select", 32'(cs_pat), 32'(e.cs));
                        check("mosi_word", 32'(slv_cap), 32'(e.tx));
                    end
                    check("sclk_idle", 32'(sclk), 32'(e.cpol));
                    check("cs_idle", 32'(cs_n), 32'({NCS{1'b1}}));
                    check("mosi_idle", 32'(mosi), 32'(0));
                end
                busy_cnt  = 0;
                edge_base = sclk_edges;
                fall_base = cs_falls;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input logic [1:0] mode,
                        input logic [DIVW-1:0] d, input logic [CSW-1:0] cs, input logic lb);
        exp_t e;
        wait_idle();
        data_in  = tx;
        cpol     = mode[1];
        cpha     = mode[0];
        div      = d;
        cs_sel   = cs;
        slv_word = sw;
        slv_cpol = mode[1];
        slv_cpha = mode[0];
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = lb;
`endif
        start    = 1'b1;
        e.tx     = tx;
        e.rx     = lb ? tx : sw;
        e.cs     = {NCS{1'b1}};
        e.cs[(int'(cs) >= NCS) ? 0 : int'(cs)] = 1'b0;
        e.busy   = (2 * DW + 2) * (int'(d) + 1);
        e.edges  = lb ? 0 : 2 * DW;
        e.falls  = lb ? 0 : 1;
        e.cpol   = mode[1];
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        check("rst_cs", 32'(cs_n), 32'({NCS{1'b1}}));
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        xfer(8'hA5, 8'h3C, SPI_MODE0, 8'd0, 3'd0, 1'b0);
        xfer(8'h81, 8'hF0, SPI_MODE3, 8'd3, 3'd2, 1'b0);

        // A start pulse mid-transfer must be ignored.
        xfer(8'hC3, 8'h69, SPI_MODE1, 8'd2, 3'd1, 1'b0);
        repeat (10) @(negedge clk);
        data_in = 8'hFF; cpol = 1'b1; cpha = 1'b0; div = 8'd0; cs_sel = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        xfer(8'h3E, 8'hB7, SPI_MODE2, 8'd1, 3'd5, 1'b0);
        xfer(8'h11, 8'h22, SPI_MODE0, 8'd0, 3'd7, 1'b0);
        xfer(8'h4D, 8'h88, SPI_MODE1, 8'd0, 3'd4, 1'b0);

        // Reset during bit 4 of a mode-0, div=1 transfer.
        xfer(8'h96, 8'h5A, SPI_MODE0, 8'd1, 3'd3, 1'b0);
        repeat (18) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs", 32'(cs_n), 32'({NCS{1'b1}}));
        check("midrst_sclk", 32'(sclk), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_data", 32'(data_out), 32'(0));
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("postrst_data", 32'(data_out), 32'(0));

        for (int i = 0; i < 24; i++) begin
            xfer(DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)),
                 DIVW'($urandom_range(0, 3)), CSW'($urandom_range(0, 7)), 1'b0);
        end

        xfer(DW'($urandom), DW'($urandom), SPI_MODE1, 8'hFF, 3'd1, 1'b0);

`ifdef SPI_MASTER_LOOPBACK_EN
        xfer(8'h5A, 8'hC3, SPI_MODE0, 8'd1, 3'd1, 1'b1);
        xfer(DW'($urandom), DW'($urandom), SPI_MODE3, 8'd0, 3'd2, 1'b1);
        xfer(DW'($urandom), DW'($urandom), SPI_MODE2, 8'd2, 3'd3, 1'b0);
`endif

        wait_idle();
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
